// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_seq_pkg: opcode constants and FSM encoding for the sequencer    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB_AB = 3'd1;
    localparam logic [2:0] OP_SUB_BA = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_DIV_AB = 3'd4;
    localparam logic [2:0] OP_DIV_BA = 3'd5;
    localparam logic [2:0] OP_AND    = 3'd6;
    localparam logic [2:0] OP_OR     = 3'd7;

    typedef enum logic [2:0] {
        ST_GET_OP  = 3'd0,
        ST_GET_OPS = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } seq_state_t;

    function automatic logic is_div0(input logic [2:0] op, input logic [3:0] a,
                                     input logic [3:0] b);
        return ((op == OP_DIV_AB) && (b == 4'd0)) || ((op == OP_DIV_BA) && (a == 4'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_seq_result_fifo: byte FIFO for ALU results, head shown unregd.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_seq_result_fifo #(
    parameter int RES_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic [$clog2(RES_DEPTH):0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int c_AW = $clog2(RES_DEPTH);

    logic [7:0]      r_mem [RES_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_AW+1)'(RES_DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_cmd_sequencer: byte-serial command feeder for a registered ALU  |
// | Optional: ALU_SEQ_DIV0_FLAG_EN adds div0_err and 8'hFF substitution.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT   = 1,
    parameter int RES_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
`ifdef ALU_SEQ_DIV0_FLAG_EN
    output logic       div0_err,
`endif
    output logic       busy
);
    localparam int c_CW = $clog2(RES_DEPTH) + 1;

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [2:0]      r_op_pend;
    logic [3:0]      r_alu_a;
    logic [3:0]      r_alu_b;
    logic [2:0]      r_alu_op;
    logic [2:0]      r_lat_cnt;
    logic            w_xfer;
    logic            w_push;
    logic [7:0]      w_push_data;
    logic [c_CW-1:0] w_count;
    logic            w_empty;
    logic            w_full;

    assign w_xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_GET_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_GET_OP: begin
                in_ready = (w_count < c_CW'(RES_DEPTH));
                if (in_valid && in_ready) begin
                    w_state_nxt = ST_GET_OPS;
                end
            end
            ST_GET_OPS: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat_cnt == 3'd1) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_push      = 1'b1;
                w_state_nxt = ST_GET_OP;
            end
            default: begin
                w_state_nxt = ST_GET_OP;
            end
        endcase
    end

    // The ALU operand/opcode lines move only when a full command has arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_pend <= 3'd0;
            r_alu_a   <= 4'd0;
            r_alu_b   <= 4'd0;
            r_alu_op  <= 3'd0;
            r_lat_cnt <= 3'd0;
        end else begin
            if (r_state == ST_GET_OP && w_xfer) begin
                r_op_pend <= in_data[2:0];
            end
            if (r_state == ST_GET_OPS && w_xfer) begin
                r_alu_a  <= in_data[7:4];
                r_alu_b  <= in_data[3:0];
                r_alu_op <= r_op_pend;
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= 3'(ALU_LAT);
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end
        end
    end

`ifdef ALU_SEQ_DIV0_FLAG_EN
    logic r_div0_err;
    logic w_div0;

    assign w_div0      = is_div0(r_alu_op, r_alu_a, r_alu_b);
    assign w_push_data = w_div0 ? 8'hFF : alu_result;
    assign div0_err    = r_div0_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div0_err <= 1'b0;
        end else begin
            r_div0_err <= w_push && w_div0;
        end
    end
`else
    assign w_push_data = alu_result;
`endif

    alu_seq_result_fifo #(
        .RES_DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push && !w_full),
        .i_pop   (res_ready),
        .i_data  (w_push_data),
        .o_data  (res_data),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign res_valid = !w_empty;
    assign busy      = (r_state != ST_GET_OP);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_cmd_sequencer: directed + random bench with a queue model    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_alu_cmd_sequencer;
    localparam int ALU_LAT   = 1;
    localparam int RES_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       busy;
`ifdef ALU_SEQ_DIV0_FLAG_EN
    logic       div0_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .ALU_LAT   (ALU_LAT),
        .RES_DEPTH (RES_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
`ifdef ALU_SEQ_DIV0_FLAG_EN
        .div0_err   (div0_err),
`endif
        .busy       (busy)
    );

    // Modelled ALU: logic ops echo A in the high nibble, divide by zero yields 0.
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            3'd0:    return {4'h0, a} + {4'h0, b};
            3'd1:    return {4'h0, a} - {4'h0, b};
            3'd2:    return {4'h0, b} - {4'h0, a};
            3'd3:    return {4'h0, a} * {4'h0, b};
            3'd4:    return (b == 0) ? 8'h00 : {4'h0, a / b};
            3'd5:    return (a == 0) ? 8'h00 : {4'h0, b / a};
            3'd6:    return {a, a & b};
            default: return {a, a | b};
        endcase
    endfunction

    function automatic logic [7:0] exp_res(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
`ifdef ALU_SEQ_DIV0_FLAG_EN
        if ((op == 3'd4 && b == 0) || (op == 3'd5 && a == 0)) return 8'hFF;
`endif
        return alu_f(op, a, b);
    endfunction

    logic [7:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_op, alu_a, alu_b);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0);
        send_byte(b1);
        exp_q.push_back(exp_res(b0[2:0], b1[7:4], b1[3:0]));
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (res_valid !== 1'b1 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 500) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        res_ready = 1'b1;
        while (res_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {24'd0, res_data}, {24'd0, e});
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        int k;
        logic [7:0] b0;
        logic [7:0] b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {24'd0, res_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu", {21'd0, alu_a, alu_b, alu_op}, 32'd0);

        // ADD with latency measurement from the byte-1 edge
        send_cmd(8'h00, 8'h35);
        chk("add_alu_a", {28'd0, alu_a}, 32'd3);
        chk("add_alu_b", {28'd0, alu_b}, 32'd5);
        chk("add_busy", {31'd0, busy}, 32'd1);
        wait_valid(k);
        chk("add_latency", k, ALU_LAT + 2);
        chk("add_data", {24'd0, res_data}, 32'h08);
        pop_check("add_pop");
        chk("add_alu_hold", {28'd0, alu_a}, 32'd3);

        // SUB_AB then MUL, popped in order
        send_cmd(8'h01, 8'h25);
        send_cmd(8'h03, 8'hFF);
        wait_idle();
        chk("sub_data", {24'd0, res_data}, 32'hFD);
        pop_check("sub_pop");
        chk("mul_data", {24'd0, res_data}, 32'hE1);
        pop_check("mul_pop");
        chk("empty_after_pops", {31'd0, res_valid}, 32'd0);

        // Backpressure: four results fill the FIFO, fifth command must stall
        for (int i = 0; i < 4; i++) send_cmd({5'd0, 3'(i)}, 8'(8'h31 + 8'(i * 17)));
        wait_idle();
        in_data  = 8'h06;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_busy_low", {31'd0, busy}, 32'd0);
        end
        pop_check("bp_pop_head");
        chk("bp_no_early_xfer", {31'd0, busy}, 32'd0);
        send_cmd(8'h06, 8'hC9);
        for (int i = 0; i < 4; i++) pop_check("bp_order");
        chk("bp_empty", {31'd0, res_valid}, 32'd0);

        // Push and pop on the same edge with two entries held
        send_cmd(8'h00, 8'h11);
        send_cmd(8'h07, 8'h48);
        wait_idle();
        send_byte(8'h03);
        send_byte(8'h67);
        exp_q.push_back(exp_res(3'd3, 4'd6, 4'd7));
        repeat (ALU_LAT + 1) @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("pp_head", {24'd0, res_data}, {24'd0, exp_q[0]});
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("pp_idle", {31'd0, busy}, 32'd0);
        pop_check("pp_pop1");
        pop_check("pp_pop2");
        chk("pp_count2", {31'd0, res_valid}, 32'd0);

        // Reset mid-command with a result already queued
        send_cmd(8'h02, 8'h9A);
        wait_idle();
        send_byte(8'h03);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, res_data}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_alu", {21'd0, alu_a, alu_b, alu_op}, 32'd0);
        send_cmd(8'h07, 8'h12);
        wait_valid(k);
        chk("mid_or_data", {24'd0, res_data}, 32'h13);
        pop_check("mid_or_pop");

        // Reset while waiting on the ALU discards the command
        send_byte(8'h00);
        send_byte(8'h44);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (ALU_LAT + 4) @(posedge clk);
        #1;
        chk("wait_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("wait_rst_busy", {31'd0, busy}, 32'd0);

        // Divide by zero on DIV_AB
        send_cmd(8'h04, 8'h70);
        wait_valid(k);
`ifdef ALU_SEQ_DIV0_FLAG_EN
        chk("div0_pulse", {31'd0, div0_err}, 32'd1);
        chk("div0_data", {24'd0, res_data}, 32'hFF);
        @(posedge clk);
        #1;
        chk("div0_pulse_end", {31'd0, div0_err}, 32'd0);
`endif
        pop_check("div0_pop");

        // Randomised commands against the queue model
        for (int i = 0; i < 30; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            if (exp_q.size() >= RES_DEPTH) pop_check("rnd_pop_full");
            send_cmd(b0, b1);
            chk("rnd_alu", {21'd0, alu_a, alu_b, alu_op}, {21'd0, b1, b0[2:0]});
            if ($urandom_range(0, 3) == 0) begin
                while (exp_q.size() > 0) pop_check("rnd_drain");
            end
        end
        while (exp_q.size() > 0) pop_check("rnd_final");
        chk("rnd_empty", {31'd0, res_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
